edp_mpy_seq: RTL and testbench
==============================

Name: edp_mpy_seq

Overview:
- Sequencer that runs a radix-4 Booth multiply on the EBOX datapath (AD/ADX adders, AR/ARX/MQ registers).
- Per cycle it drives the datapath select, function and load strobes in place of CRAM/CTL decode while a multiply is in progress.
- Multiplicand is in BR/BRX and multiplier in MQ. The product accumulates in AR:ARX and shifts right two bits per step through the AR/ARX/MQ shift-by-2 mux legs.

Parameters:
- N_STEPS, 18, number of radix-4 Booth steps (36-bit multiplier / 2).
- CNT_W, 5, width of the step counter; must satisfy 2**CNT_W > N_STEPS.

Ports:
- clk  input  1  EDP clock (CLK.EDP)
- reset  input  1  synchronous, active-high
- start  input  1  request to begin a multiply; sampled only in IDLE
- abort  input  1  synchronous cancel, e.g. page fail or interrupt
- mq_lo  input  2  live MQ[34:35]
- busy  output  1  high from the cycle after start is accepted until DONE completes
- done  output  1  one-cycle pulse in DONE
- ada_sel  output  3  ADA mux code; 3'b000 = AR
- adb_sel  output  2  ADB mux code; 2'b10 = BR, 2'b01 = 2*BR
- ad_fn  output  6  AD/ADX function, CRAM.AD encoding
- ad_long  output  1  link ADX carry into AD
- arl_sel  output  3  ARL mux select
- arxl_sel, arxr_sel  output  3 each  ARX mux selects
- mqm_en  output  1  MQM mux enable
- mqm_sel  output  2  MQM mux select
- mq_sel  output  2  MQ USR mode
- ar_clr  output  1  clears AR via the ARM clear gates
- ar_load  output  1  loads AR (all three segments)
- arx_load  output  1  loads ARX

Behaviour:
- States: IDLE, INIT, STEP, DONE.
- Reset values: state=IDLE, count=0, booth_prev=0. Every output is 0 except mq_sel, which is MQ_HOLD.
- IDLE:
  - start=1 → INIT next cycle.
  - Otherwise all strobes stay 0 and mq_sel=MQ_HOLD.
- INIT (1 cycle):
  - ar_clr=1, ar_load=1, arx_load=1, arxl_sel=arxr_sel=3'b000 (AR:ARX ← 0).
  - booth_prev←0, count←N_STEPS-1 → STEP.
- STEP (N_STEPS cycles). Booth digit d = f({mq_lo[0], mq_lo[1], booth_prev}):
  - 000, 111 → 0: ad_fn=AD_PASS_A
  - 001, 010 → +B: ad_fn=AD_A_PLUS_B, adb_sel=BR
  - 011 → +2B: ad_fn=AD_A_PLUS_B, adb_sel=BR2
  - 100 → -2B: ad_fn=AD_A_MINUS_B, adb_sel=BR2
  - 101, 110 → -B: ad_fn=AD_A_MINUS_B, adb_sel=BR
- Fixed STEP outputs:
  - ada_sel=000, ad_long=1, ar_load=1, arx_load=1.
  - arl_sel=3'b111 (AD_EX:AD>>2), arxl_sel=arxr_sel=3'b111 (AD:ADX>>2).
  - mqm_en=1, mqm_sel=2'b00 ({ADX[34:35],MQ[0:33]}), mq_sel=MQ_LOAD.
- STEP register updates:
  - booth_prev←mq_lo[0] each step.
  - count decrements each step; count==0 in STEP → DONE. STEP therefore lasts exactly N_STEPS cycles.
- DONE (1 cycle): done=1, busy=1, all loads 0 → IDLE.
- Latency: start sampled in cycle 0 → done high in cycle N_STEPS+2.
- start while not in IDLE is ignored; there is no queueing.
- abort in INIT, STEP or DONE:
  - → IDLE next cycle with all strobes 0 in that next cycle.
  - The abort cycle itself still drives the current state's outputs.
  - done is not pulsed.
- abort takes priority over a count==0 transition.
- reset has priority over abort and start in every state.
- start and abort together in IDLE: abort wins, stay in IDLE.
- Result: product high word in AR, low word in ARX. Signed two's-complement.

Optional Feature:
- EDP_MPY_EARLY_EXIT_EN.
- When defined: input mq_uniform (1 bit) is true when all remaining unconsumed MQ bits equal booth_prev.
  - In STEP, if mq_uniform=1 and the digit is 0, go to a PAD state.
  - PAD performs the remaining count+1 shifts with ad_fn=AD_PASS_A and no adder activity.
  - Cycle count is unchanged.
  - Adds output idle_steps[CNT_W] reporting skipped digits for power and perf counters.
- When undefined: the port, the PAD state and idle_steps are absent.

Decomposition:
- Package edp_seq_pkg holds:
  - state enum mpy_state_t {IDLE, INIT, STEP, DONE[, PAD]};
  - constants AD_PASS_A, AD_A_PLUS_B, AD_A_MINUS_B (6-bit CRAM.AD values);
  - ADB_BR=2'b10, ADB_BR2=2'b01;
  - MQ_HOLD, MQ_LOAD (USR4 SEL codes).
- One sub-module: edp_booth4_dec, a combinational map {mq_lo, booth_prev} → {ad_fn, adb_sel}.

Test Plan:
- BR=3, MQ=5, start → done at cycle 20 (start sampled in cycle 0); AR=0, ARX=15; busy high in cycles 1..20.
- BR=-1, MQ=-1 → AR:ARX=1. BR=400000000000 (most negative), MQ=-1 → AR=0, ARX=400000000000 (octal).
- Digit coverage: drive every one of the 8 {mq_lo, prev} combinations → ad_fn/adb_sel match the table above.
- abort in STEP cycle 7 → IDLE next cycle, all strobes 0, no done; a second start then completes normally.
- start held high continuously → exactly one multiply per N_STEPS+3 cycles. reset in STEP → outputs at reset values next cycle.

Source files
------------

// File: rtl/edp_mpy_seq_pkg.sv
// Shared types and datapath control codes for the EBOX radix-4 Booth multiply sequencer.
// The PAD state exists only when EDP_MPY_EARLY_EXIT_EN is defined.
package edp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    STEP = 3'd2,
    DONE = 3'd3
`ifdef EDP_MPY_EARLY_EXIT_EN
    ,
    PAD  = 3'd4
`endif
  } mpy_state_t;

  // CRAM.AD function codes
  localparam logic [5:0] AD_PASS_A    = 6'o37;
  localparam logic [5:0] AD_A_PLUS_B  = 6'o06;
  localparam logic [5:0] AD_A_MINUS_B = 6'o31;

  localparam logic [1:0] ADB_BR  = 2'b10;
  localparam logic [1:0] ADB_BR2 = 2'b01;

  // USR4 select codes for the MQ shift register
  localparam logic [1:0] MQ_HOLD = 2'b00;
  localparam logic [1:0] MQ_LOAD = 2'b11;

  localparam logic [2:0] ADA_AR   = 3'b000;
  localparam logic [2:0] SEL_SHR2 = 3'b111;
  localparam logic [2:0] SEL_ZERO = 3'b000;

endpackage

// File: rtl/edp_booth4_dec.sv
// Radix-4 Booth digit decode: {MQ34, MQ35, previous MQ34} to AD function and ADB select.
module edp_booth4_dec
  import edp_seq_pkg::*;
(
  input  logic [1:0] i_mq_lo,
  input  logic       i_booth_prev,
  output logic [5:0] o_ad_fn,
  output logic [1:0] o_adb_sel
);

  logic [2:0] w_trip;

  // i_mq_lo[0] is MQ34, the more significant bit of the pair
  assign w_trip = {i_mq_lo[0], i_mq_lo[1], i_booth_prev};

  always_comb begin
    o_ad_fn   = AD_PASS_A;
    o_adb_sel = 2'b00;
    case (w_trip)
      3'b000, 3'b111: begin
        o_ad_fn   = AD_PASS_A;
        o_adb_sel = 2'b00;
      end
      3'b001, 3'b010: begin
        o_ad_fn   = AD_A_PLUS_B;
        o_adb_sel = ADB_BR;
      end
      3'b011: begin
        o_ad_fn   = AD_A_PLUS_B;
        o_adb_sel = ADB_BR2;
      end
      3'b100: begin
        o_ad_fn   = AD_A_MINUS_B;
        o_adb_sel = ADB_BR2;
      end
      default: begin
        o_ad_fn   = AD_A_MINUS_B;
        o_adb_sel = ADB_BR;
      end
    endcase
  end

endmodule

// File: rtl/edp_mpy_seq.sv
// Radix-4 Booth multiply sequencer driving EBOX AD/AR/ARX/MQ controls while a multiply runs.
// Optional early-exit padding (i_mq_uniform, o_idle_steps, PAD state) under EDP_MPY_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for i_start, datapath untouched
// INIT  | clear AR:ARX, preload step counter
// STEP  | one Booth digit: AD = AR op BR/2*BR, shift AR:ARX:MQ right 2
// PAD   | remaining shifts with AD passing AR (early exit only)
// DONE  | one-cycle completion pulse
module edp_mpy_seq
  import edp_seq_pkg::*;
#(
  parameter int N_STEPS = 18,
  parameter int CNT_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [1:0]       i_mq_lo,
`ifdef EDP_MPY_EARLY_EXIT_EN
  input  logic             i_mq_uniform,
  output logic [CNT_W-1:0] o_idle_steps,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_ada_sel,
  output logic [1:0]       o_adb_sel,
  output logic [5:0]       o_ad_fn,
  output logic             o_ad_long,
  output logic [2:0]       o_arl_sel,
  output logic [2:0]       o_arxl_sel,
  output logic [2:0]       o_arxr_sel,
  output logic             o_mqm_en,
  output logic [1:0]       o_mqm_sel,
  output logic [1:0]       o_mq_sel,
  output logic             o_ar_clr,
  output logic             o_ar_load,
  output logic             o_arx_load
);

  mpy_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_booth_prev, w_prev_nxt;
  logic [5:0]       w_dec_fn;
  logic [1:0]       w_dec_adb;
  logic             w_shift;

  edp_booth4_dec u_dec (
    .i_mq_lo      (i_mq_lo),
    .i_booth_prev (r_booth_prev),
    .o_ad_fn      (w_dec_fn),
    .o_adb_sel    (w_dec_adb)
  );

`ifdef EDP_MPY_EARLY_EXIT_EN
  logic [CNT_W-1:0] r_idle_steps, w_idle_nxt;
  assign o_idle_steps = r_idle_steps;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_booth_prev <= 1'b0;
`ifdef EDP_MPY_EARLY_EXIT_EN
      r_idle_steps <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_booth_prev <= w_prev_nxt;
`ifdef EDP_MPY_EARLY_EXIT_EN
      r_idle_steps <= w_idle_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_prev_nxt  = r_booth_prev;
    w_shift     = 1'b0;
`ifdef EDP_MPY_EARLY_EXIT_EN
    w_idle_nxt  = r_idle_steps;
`endif
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_ada_sel   = ADA_AR;
    o_adb_sel   = 2'b00;
    o_ad_fn     = 6'b0;
    o_ad_long   = 1'b0;
    o_arl_sel   = 3'b000;
    o_arxl_sel  = 3'b000;
    o_arxr_sel  = 3'b000;
    o_mqm_en    = 1'b0;
    o_mqm_sel   = 2'b00;
    o_mq_sel    = MQ_HOLD;
    o_ar_clr    = 1'b0;
    o_ar_load   = 1'b0;
    o_arx_load  = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = INIT;
      end
      INIT: begin
        o_busy      = 1'b1;
        o_ar_clr    = 1'b1;
        o_ar_load   = 1'b1;
        o_arx_load  = 1'b1;
        o_arxl_sel  = SEL_ZERO;
        o_arxr_sel  = SEL_ZERO;
        w_prev_nxt  = 1'b0;
        w_count_nxt = CNT_W'(N_STEPS - 1);
        w_state_nxt = STEP;
`ifdef EDP_MPY_EARLY_EXIT_EN
        w_idle_nxt  = '0;
`endif
      end
      STEP: begin
        o_busy      = 1'b1;
        w_shift     = 1'b1;
        o_ad_fn     = w_dec_fn;
        o_adb_sel   = w_dec_adb;
        w_prev_nxt  = i_mq_lo[0];
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == '0) begin
          w_state_nxt = DONE;
        end
`ifdef EDP_MPY_EARLY_EXIT_EN
        // all remaining digits are zero: stop exercising the adder
        else if (i_mq_uniform && (w_dec_fn == AD_PASS_A)) begin
          w_state_nxt = PAD;
          w_idle_nxt  = r_count + CNT_W'(1);
        end
`endif
      end
`ifdef EDP_MPY_EARLY_EXIT_EN
      PAD: begin
        o_busy      = 1'b1;
        w_shift     = 1'b1;
        o_ad_fn     = AD_PASS_A;
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == '0) w_state_nxt = DONE;
      end
`endif
      DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_shift) begin
      o_ada_sel  = ADA_AR;
      o_ad_long  = 1'b1;
      o_ar_load  = 1'b1;
      o_arx_load = 1'b1;
      o_arl_sel  = SEL_SHR2;
      o_arxl_sel = SEL_SHR2;
      o_arxr_sel = SEL_SHR2;
      o_mqm_en   = 1'b1;
      o_mqm_sel  = 2'b00;
      o_mq_sel   = MQ_LOAD;
    end

    // abort outranks every transition, including count==0 and start
    if (i_abort) w_state_nxt = IDLE;
  end

endmodule

// File: tb/tb_edp_mpy_seq.sv
// Bench for edp_mpy_seq: emulates the AR/ARX/MQ datapath from the DUT strobes and checks
// per-cycle control outputs and final products against arithmetic expectations.
module tb_edp_mpy_seq;
  import edp_seq_pkg::*;

  localparam int N_STEPS = 18;
  localparam int CNT_W   = 5;
  localparam int DONE_PH = N_STEPS + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mq_lo = 2'b00;
  logic       busy, done, ad_long, mqm_en, ar_clr, ar_load, arx_load;
  logic [2:0] ada_sel, arl_sel, arxl_sel, arxr_sel;
  logic [1:0] adb_sel, mqm_sel, mq_sel;
  logic [5:0] ad_fn;
`ifdef EDP_MPY_EARLY_EXIT_EN
  logic             mq_uniform = 1'b0;
  logic [CNT_W-1:0] idle_steps;
`endif

  edp_mpy_seq #(.N_STEPS(N_STEPS), .CNT_W(CNT_W)) dut (
`ifdef EDP_MPY_EARLY_EXIT_EN
    .i_mq_uniform (mq_uniform),
    .o_idle_steps (idle_steps),
`endif
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_abort    (abort),
    .i_mq_lo    (mq_lo),
    .o_busy     (busy),
    .o_done     (done),
    .o_ada_sel  (ada_sel),
    .o_adb_sel  (adb_sel),
    .o_ad_fn    (ad_fn),
    .o_ad_long  (ad_long),
    .o_arl_sel  (arl_sel),
    .o_arxl_sel (arxl_sel),
    .o_arxr_sel (arxr_sel),
    .o_mqm_en   (mqm_en),
    .o_mqm_sel  (mqm_sel),
    .o_mq_sel   (mq_sel),
    .o_ar_clr   (ar_clr),
    .o_ar_load  (ar_load),
    .o_arx_load (arx_load)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  // model phase: -1 idle, 0 init, 1..N_STEPS booth steps, N_STEPS+1 done
  int          m_phase = -1;
  logic        m_prev = 1'b0;
  logic [35:0] m_ar = '0, m_arx = '0, m_mq = '0, m_br = '0;
  logic [35:0] nxt_br = '0, nxt_mq = '0;
  logic [71:0] m_prod = '0;
  int          done_cnt = 0, last_done_cyc = -1;
  logic [35:0] last_ar = '0, last_arx = '0;
  bit          seen [8];

  function automatic logic [35:0] rnd36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic a, input logic r);
    logic [30:0]        exp_v, obs_v, mask;
    logic [5:0]         e_fn;
    logic [1:0]         e_adb;
    logic               e_busy, e_done, e_init, e_step;
    int                 dig;
    logic signed [37:0] acc, addend;
    logic [35:0]        old_arx, old_mq;
    logic signed [71:0] pa, pb;
    start = s;
    abort = a;
    reset = r;
    mq_lo = {m_mq[0], m_mq[1]};
    #1;
    e_fn   = 6'b0;
    e_adb  = 2'b00;
    mask   = '1;
    e_busy = (m_phase >= 0);
    e_done = (m_phase == DONE_PH);
    e_init = (m_phase == 0);
    e_step = (m_phase >= 1 && m_phase <= N_STEPS);
    if (e_step) begin
      dig = -2 * int'(m_mq[1]) + int'(m_mq[0]) + int'(m_prev);
      seen[{m_mq[1], m_mq[0], m_prev}] = 1'b1;
      case (dig)
        0:  begin e_fn = AD_PASS_A;    mask[25:24] = 2'b00; end
        1:  begin e_fn = AD_A_PLUS_B;  e_adb = ADB_BR;  end
        2:  begin e_fn = AD_A_PLUS_B;  e_adb = ADB_BR2; end
        -1: begin e_fn = AD_A_MINUS_B; e_adb = ADB_BR;  end
        default: begin e_fn = AD_A_MINUS_B; e_adb = ADB_BR2; end
      endcase
    end
    exp_v = {e_busy, e_done, 3'b000, e_adb, e_fn, e_step, {3{e_step}}, {3{e_step}},
             {3{e_step}}, e_step, 2'b00, (e_step ? MQ_LOAD : MQ_HOLD), e_init,
             e_init | e_step, e_init | e_step};
    obs_v = {busy, done, ada_sel, adb_sel, ad_fn, ad_long, arl_sel, arxl_sel, arxr_sel,
             mqm_en, mqm_sel, mq_sel, ar_clr, ar_load, arx_load};
    check("outputs", 72'(obs_v & mask), 72'(exp_v & mask));
    if (e_done) check("product", {m_ar, m_arx}, m_prod);
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_ar = m_ar;
      last_arx = m_arx;
    end

    // datapath reacts to whatever the DUT drives
    old_arx = m_arx;
    old_mq  = m_mq;
    if (ar_load && ar_clr) begin
      m_ar = '0;
      if (arx_load) m_arx = '0;
    end else if (ar_load && arl_sel == 3'b111) begin
      acc    = {{2{m_ar[35]}}, m_ar};
      addend = {{2{m_br[35]}}, m_br};
      if (adb_sel == ADB_BR2) addend = addend <<< 1;
      if (ad_fn == AD_A_PLUS_B) acc = acc + addend;
      else if (ad_fn == AD_A_MINUS_B) acc = acc - addend;
      m_ar = acc[37:2];
      if (arx_load && arxl_sel == 3'b111) m_arx = {acc[1:0], old_arx[35:2]};
    end
    if (mqm_en && mqm_sel == 2'b00 && mq_sel == MQ_LOAD) m_mq = {old_arx[1:0], old_mq[35:2]};

    if (r) begin
      m_phase = -1;
      m_prev  = 1'b0;
    end else if (a && m_phase >= 0) begin
      m_phase = -1;
    end else if (m_phase < 0) begin
      if (s && !a) begin
        m_phase = 0;
        m_br = nxt_br;
        m_mq = nxt_mq;
        pa = $signed({{36{nxt_br[35]}}, nxt_br});
        pb = $signed({{36{nxt_mq[35]}}, nxt_mq});
        m_prod = pa * pb;
      end
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_prev  = 1'b0;
    end else if (m_phase <= N_STEPS) begin
      m_prev = old_mq[1];
      m_phase++;
    end else begin
      m_phase = -1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_mul(input logic [35:0] b, input logic [35:0] q, output int lat);
    int c0, d0;
    nxt_br = b;
    nxt_mq = q;
    c0 = cyc;
    d0 = done_cnt;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && done_cnt == d0; i++) tick(1'b0, 1'b0, 1'b0);
    if (done_cnt == d0) begin
      n_vec++;
      n_err++;
      $display("FAIL mul_timeout got=no_done want=done");
      lat = -1;
    end else begin
      lat = last_done_cyc - c0;
    end
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, d0, guard;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 72'({busy, done, mq_sel, ar_load, ad_fn}),
          72'({1'b0, 1'b0, MQ_HOLD, 1'b0, 6'b0}));

    run_mul(36'd3, 36'd5, lat);
    check("latency", 72'(lat), 72'(20));
    check("p_3x5", {last_ar, last_arx}, {36'd0, 36'd15});
    run_mul('1, '1, lat);
    check("p_m1xm1", {last_ar, last_arx}, {36'd0, 36'd1});
    run_mul(36'o400000000000, '1, lat);
    check("p_maxneg", {last_ar, last_arx}, {36'd0, 36'o400000000000});

    // abort in step 7, then a clean multiply
    nxt_br = rnd36();
    nxt_mq = rnd36();
    d0 = done_cnt;
    tick(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_phase != 7 && guard < 20) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    tick(1'b0, 1'b1, 1'b0);
    #1;
    check("abort_idle", 72'({busy, ar_load, arx_load, mqm_en, mq_sel}),
          72'({1'b0, 1'b0, 1'b0, 1'b0, MQ_HOLD}));
    tick(1'b0, 1'b0, 1'b0);
    check("abort_no_done", 72'(done_cnt - d0), 72'(0));
    run_mul(36'd7, 36'hFFFFFFFFD, lat);
    check("p_7xm3", {last_ar, last_arx}, {36'hFFFFFFFFF, 36'hFFFFFFFEB});

    // start and abort together in idle
    tick(1'b1, 1'b1, 1'b0);
    #1;
    check("start_abort_idle", 72'(busy), 72'(0));
    tick(1'b0, 1'b0, 1'b0);

    // reset during a step
    nxt_br = rnd36();
    nxt_mq = rnd36();
    tick(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_phase != 5 && guard < 20) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    tick(1'b0, 1'b0, 1'b1);
    #1;
    check("reset_in_step", 72'({busy, done, ar_load, arx_load, mqm_en, ad_long, mq_sel, ad_fn}),
          72'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MQ_HOLD, 6'b0}));
    tick(1'b0, 1'b0, 1'b0);

    // start held high: one multiply every N_STEPS+3 cycles
    c0 = cyc;
    d0 = done_cnt;
    for (int i = 0; i < 3 * (N_STEPS + 3); i++) begin
      nxt_br = rnd36();
      nxt_mq = rnd36();
      tick(1'b1, 1'b0, 1'b0);
    end
    check("held_count", 72'(done_cnt - d0), 72'(3));
    check("held_last", 72'(last_done_cyc - c0), 72'(3 * (N_STEPS + 3) - 1));
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // random operands with stray starts and occasional aborts
    for (int t = 0; t < 40; t++) begin
      int   ab, g;
      logic s_now;
      nxt_br = rnd36();
      nxt_mq = rnd36();
      if (t % 10 == 3) nxt_mq = '0;
      if (t % 10 == 7) nxt_br = 36'o400000000000;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_STEPS)) : -1;
      tick(1'b1, 1'b0, 1'b0);
      g = 0;
      while (m_phase >= 0 && g < 40) begin
        s_now = (m_phase <= N_STEPS) ? ($urandom_range(0, 1) == 1) : 1'b0;
        tick(s_now, (m_phase == ab), 1'b0);
        g++;
      end
      if (m_phase >= 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rand_timeout got=busy want=idle");
      end
      if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 8; i++) check($sformatf("digit_cov%0d", i), 72'(seen[i]), 72'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
